// File: rtl/vga_dither_pkg.sv
// Shared constants for the VGA ordered-dither path: pixel widths, sync polarity
// defaults and the 4x4 Bayer matrix with its 3-bit threshold lookup.
package vga_dither_pkg;

  localparam int IN_W  = 6;
  localparam int OUT_W = 3;

  localparam logic HS_ACTIVE_DEF = 1'b0;
  localparam logic VS_ACTIVE_DEF = 1'b0;

  localparam logic [3:0] BAYER4 [4][4] = '{
    '{4'd0,  4'd8,  4'd2,  4'd10},
    '{4'd12, 4'd4,  4'd14, 4'd6 },
    '{4'd3,  4'd11, 4'd1,  4'd9 },
    '{4'd15, 4'd7,  4'd13, 4'd5 }
  };

  // Top three bits of the matrix entry: threshold 0..7 against a 3-bit remainder.
  function automatic logic [2:0] bayer_thresh(input logic [1:0] y, input logic [1:0] x);
    return 3'(BAYER4[y][x] >> 1);
  endfunction

endpackage

// File: rtl/vga_ordered_dither_channel.sv
// One colour channel of stage 2: rounds 6-bit colour up to the next 3-bit level when the
// remainder beats the threshold. One registered cycle; holds when i_ce is low.
module dither_channel
  import vga_dither_pkg::*;
(
  input  logic             clk_vga,
  input  logic             rst_n,
  input  logic             i_ce,
  input  logic [IN_W-1:0]  i_c,
  input  logic [2:0]       i_t,
  input  logic             i_den,
  output logic [OUT_W-1:0] o_c
);

  logic             w_inc;
  logic [OUT_W-1:0] r_c;

  // Never step past full scale, so 7 stays 7 instead of wrapping to 0.
  assign w_inc = i_den && (i_c[2:0] > i_t) && (i_c[5:3] != 3'd7);

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      r_c <= '0;
    end else if (i_ce) begin
      r_c <= i_c[5:3] + {2'b00, w_inc};
    end
  end

  assign o_c = r_c;

endmodule

// File: rtl/vga_ordered_dither.sv
// 6-bit RGB to 3-bit VGA DAC with 4x4 ordered dithering; syncs delayed to match.
// Latency 2 pix_ce beats for colour and syncs; pix_ce low freezes all state.
module vga_ordered_dither
  import vga_dither_pkg::*;
#(
  parameter logic HS_ACTIVE = HS_ACTIVE_DEF,
  parameter logic VS_ACTIVE = VS_ACTIVE_DEF
) (
  input  logic            clk_vga,
  input  logic            rst_n,
  input  logic            pix_ce,
  input  logic [IN_W-1:0] r_in,
  input  logic [IN_W-1:0] g_in,
  input  logic [IN_W-1:0] b_in,
  input  logic            hs_in,
  input  logic            vs_in,
  input  logic            dither_en,
  input  logic            temporal_en,
  output logic [OUT_W-1:0] r_out,
  output logic [OUT_W-1:0] g_out,
  output logic [OUT_W-1:0] b_out,
  output logic            hs_out,
  output logic            vs_out
);

  logic [IN_W-1:0] r_s1_r;
  logic [IN_W-1:0] r_s1_g;
  logic [IN_W-1:0] r_s1_b;
  logic            r_s1_hs;
  logic            r_s1_vs;
  logic            r_s1_den;
  logic [2:0]      r_s1_t;
  logic            r_hs_out;
  logic            r_vs_out;
  logic [1:0]      r_x;
  logic [1:0]      r_y;
  logic            r_phase;

  logic            w_hs_act;
  logic            w_hs_edge;
  logic            w_vs_edge;
  logic [1:0]      w_xi;
  logic [2:0]      w_t;

  // Edges compare the incoming sync with the previous sample held in stage 1.
  assign w_hs_act  = (hs_in == HS_ACTIVE);
  assign w_hs_edge = w_hs_act && (r_s1_hs != HS_ACTIVE);
  assign w_vs_edge = (vs_in == VS_ACTIVE) && (r_s1_vs != VS_ACTIVE);
  assign w_xi      = r_x ^ {2{r_phase & temporal_en}};
  assign w_t       = bayer_thresh(r_y, w_xi);

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_r   <= '0;
      r_s1_g   <= '0;
      r_s1_b   <= '0;
      r_s1_hs  <= ~HS_ACTIVE;
      r_s1_vs  <= ~VS_ACTIVE;
      r_s1_den <= 1'b0;
      r_s1_t   <= '0;
      r_hs_out <= ~HS_ACTIVE;
      r_vs_out <= ~VS_ACTIVE;
    end else if (pix_ce) begin
      r_s1_r   <= r_in;
      r_s1_g   <= g_in;
      r_s1_b   <= b_in;
      r_s1_hs  <= hs_in;
      r_s1_vs  <= vs_in;
      r_s1_den <= dither_en;
      r_s1_t   <= w_t;
      r_hs_out <= r_s1_hs;
      r_vs_out <= r_s1_vs;
    end
  end

  // vsync is applied after hsync so a coincident pair lands on row 0.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      r_x     <= '0;
      r_y     <= '0;
      r_phase <= 1'b0;
    end else if (pix_ce) begin
      if (w_hs_edge) begin
        r_x <= '0;
      end else if (!w_hs_act) begin
        r_x <= r_x + 2'd1;
      end
      if (w_vs_edge) begin
        r_y     <= '0;
        r_phase <= ~r_phase;
      end else if (w_hs_edge) begin
        r_y <= r_y + 2'd1;
      end
    end
  end

  dither_channel u_ch_r (
    .clk_vga (clk_vga),
    .rst_n   (rst_n),
    .i_ce    (pix_ce),
    .i_c     (r_s1_r),
    .i_t     (r_s1_t),
    .i_den   (r_s1_den),
    .o_c     (r_out)
  );

  dither_channel u_ch_g (
    .clk_vga (clk_vga),
    .rst_n   (rst_n),
    .i_ce    (pix_ce),
    .i_c     (r_s1_g),
    .i_t     (r_s1_t),
    .i_den   (r_s1_den),
    .o_c     (g_out)
  );

  dither_channel u_ch_b (
    .clk_vga (clk_vga),
    .rst_n   (rst_n),
    .i_ce    (pix_ce),
    .i_c     (r_s1_b),
    .i_t     (r_s1_t),
    .i_den   (r_s1_den),
    .o_c     (b_out)
  );

  assign hs_out = r_hs_out;
  assign vs_out = r_vs_out;

endmodule
